// File: rtl/addsub_share_ctrl.sv
// addsub_share_ctrl
// Two-requester controller that time-shares one signed add/subtract
// datapath. Requests are arbitrated round-robin in IDLE. The accepted
// operands are latched and evaluated in EXEC. The registered result is held
// in RESP until the owning requester takes it.
//
// Parameters:
//   WIDTH  - operand/result width (two's complement)
//   SAT_EN - 1: saturate RSP_Y on signed overflow, 0: wrap
//   CNT_W  - width of the completed-operation counter
//
// Ports:
//   CLK, RST                  - clock, synchronous active-high reset
//   REQx_VALID/SEL/A/B        - request x: operation valid, 0=A+B / 1=A-B, operands
//   REQx_READY                - request x accepted this cycle (IDLE only)
//   RSPx_VALID / RSPx_READY   - result owned by requester x / requester x takes it
//   RSP_Y, RSP_OF             - registered result and signed-overflow flag
//   BUSY                      - high in EXEC and RESP
//   OP_CNT                    - completed-operation count (wraps)
module addsub_share_ctrl #(
    parameter int WIDTH  = 6,
    parameter bit SAT_EN = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    input  logic             REQ0_SEL,
    input  logic [WIDTH-1:0] REQ0_A,
    input  logic [WIDTH-1:0] REQ0_B,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic             REQ1_SEL,
    input  logic [WIDTH-1:0] REQ1_A,
    input  logic [WIDTH-1:0] REQ1_B,
    output logic             REQ1_READY,
    output logic             RSP0_VALID,
    output logic             RSP1_VALID,
    input  logic             RSP0_READY,
    input  logic             RSP1_READY,
    output logic [WIDTH-1:0] RSP_Y,
    output logic             RSP_OF,
    output logic             BUSY,
    output logic [CNT_W-1:0] OP_CNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             state, state_nxt;
    logic               prio;
    logic               owner;
    logic               op_sel;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               rsp0_valid;
    logic               rsp1_valid;
    logic [WIDTH-1:0]   rsp_y;
    logic               rsp_of;
    logic [CNT_W-1:0]   op_cnt;

    logic               grant_any;
    logic               grant_id;
    logic               owner_ready;

    logic [WIDTH-1:0]   bx;
    logic [WIDTH:0]     sum;
    logic               of_calc;
    logic [WIDTH-1:0]   y_calc;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Grant: a lone valid requester always wins; a tie goes to PRIO.
    assign grant_any   = REQ0_VALID | REQ1_VALID;
    assign grant_id    = (REQ0_VALID & REQ1_VALID) ? prio : REQ1_VALID;
    assign owner_ready = owner ? RSP1_READY : RSP0_READY;

    // Shared adder: subtraction as A + ~B + 1. The carry-out (sum[WIDTH]) is unused.
    assign bx      = op_sel ? ~op_b : op_b;
    assign sum     = {1'b0, op_a} + {1'b0, bx} + {{WIDTH{1'b0}}, op_sel};
    assign of_calc = (~op_a[WIDTH-1] & ~bx[WIDTH-1] &  sum[WIDTH-1]) |
                     ( op_a[WIDTH-1] &  bx[WIDTH-1] & ~sum[WIDTH-1]);

    always_comb begin
        y_calc = sum[WIDTH-1:0];
        if (SAT_EN && of_calc) begin
            y_calc = op_a[WIDTH-1] ? MIN_NEG : MAX_POS;
        end
    end

    always_comb begin
        state_nxt  = state;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    REQ0_READY = ~grant_id;
                    REQ1_READY =  grant_id;
                    state_nxt  = S_EXEC;
                end
            end
            S_EXEC: state_nxt = S_RESP;
            S_RESP: begin
                if (owner_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            prio       <= 1'b0;
            owner      <= 1'b0;
            op_sel     <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_y      <= '0;
            rsp_of     <= 1'b0;
            op_cnt     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        owner  <= grant_id;
                        prio   <= ~grant_id;
                        op_sel <= grant_id ? REQ1_SEL : REQ0_SEL;
                        op_a   <= grant_id ? REQ1_A   : REQ0_A;
                        op_b   <= grant_id ? REQ1_B   : REQ0_B;
                    end
                end
                S_EXEC: begin
                    rsp_y      <= y_calc;
                    rsp_of     <= of_calc;
                    rsp0_valid <= ~owner;
                    rsp1_valid <=  owner;
                end
                S_RESP: begin
                    if (owner_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        op_cnt     <= op_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RSP0_VALID = rsp0_valid;
    assign RSP1_VALID = rsp1_valid;
    assign RSP_Y      = rsp_y;
    assign RSP_OF     = rsp_of;
    assign BUSY       = (state != S_IDLE);
    assign OP_CNT     = op_cnt;

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Directed bench for addsub_share_ctrl. A wrapping instance and a
// saturating instance share all inputs. Saturating results are checked
// only on the single-operation steps.
module tb_addsub_share_ctrl;

    localparam int WIDTH = 6;
    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             REQ0_VALID, REQ0_SEL, REQ1_VALID, REQ1_SEL;
    logic [WIDTH-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
    logic             RSP0_READY, RSP1_READY;

    logic             REQ0_READY, REQ1_READY, RSP0_VALID, RSP1_VALID, RSP_OF, BUSY;
    logic [WIDTH-1:0] RSP_Y;
    logic [CNT_W-1:0] OP_CNT;

    logic             s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid, s_rsp_of, s_busy;
    logic [WIDTH-1:0] s_rsp_y;
    logic [CNT_W-1:0] s_op_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    addsub_share_ctrl #(.WIDTH(WIDTH), .SAT_EN(1'b0), .CNT_W(CNT_W)) u_wrap (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_SEL(REQ0_SEL), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
        .REQ0_READY(REQ0_READY),
        .REQ1_VALID(REQ1_VALID), .REQ1_SEL(REQ1_SEL), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .REQ1_READY(REQ1_READY),
        .RSP0_VALID(RSP0_VALID), .RSP1_VALID(RSP1_VALID),
        .RSP0_READY(RSP0_READY), .RSP1_READY(RSP1_READY),
        .RSP_Y(RSP_Y), .RSP_OF(RSP_OF), .BUSY(BUSY), .OP_CNT(OP_CNT)
    );

    addsub_share_ctrl #(.WIDTH(WIDTH), .SAT_EN(1'b1), .CNT_W(CNT_W)) u_sat (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_SEL(REQ0_SEL), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
        .REQ0_READY(s_req0_ready),
        .REQ1_VALID(REQ1_VALID), .REQ1_SEL(REQ1_SEL), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
        .REQ1_READY(s_req1_ready),
        .RSP0_VALID(s_rsp0_valid), .RSP1_VALID(s_rsp1_valid),
        .RSP0_READY(RSP0_READY), .RSP1_READY(RSP1_READY),
        .RSP_Y(s_rsp_y), .RSP_OF(s_rsp_of), .BUSY(s_busy), .OP_CNT(s_op_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step to 2 time units after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    // One isolated operation by requester id; result taken immediately after it is observed.
    task automatic run_single(input string tag, input logic id, input logic sel,
                              input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [WIDTH-1:0] ey, input logic eof,
                              input logic [WIDTH-1:0] sy, input logic sof,
                              input logic [CNT_W-1:0] cnt_before);
        if (id) begin
            REQ1_VALID = 1'b1; REQ1_SEL = sel; REQ1_A = a; REQ1_B = b;
        end else begin
            REQ0_VALID = 1'b1; REQ0_SEL = sel; REQ0_A = a; REQ0_B = b;
        end
        settle();
        chk({tag, "_ready0"}, REQ0_READY, !id);
        chk({tag, "_ready1"}, REQ1_READY, id);
        tick();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        settle();
        chk({tag, "_exec_busy"}, BUSY, 1'b1);
        chk({tag, "_exec_ready"}, {REQ0_READY, REQ1_READY}, 2'b00);
        chk({tag, "_exec_rspv"}, {RSP0_VALID, RSP1_VALID}, 2'b00);
        tick();
        settle();
        chk({tag, "_rspv"}, {RSP1_VALID, RSP0_VALID}, id ? 2'b10 : 2'b01);
        chk({tag, "_y"}, RSP_Y, ey);
        chk({tag, "_of"}, RSP_OF, eof);
        chk({tag, "_sat_y"}, s_rsp_y, sy);
        chk({tag, "_sat_of"}, s_rsp_of, sof);
        chk({tag, "_cnt_hold"}, OP_CNT, cnt_before);
        if (id) RSP1_READY = 1'b1; else RSP0_READY = 1'b1;
        tick();
        RSP0_READY = 1'b0;
        RSP1_READY = 1'b0;
        settle();
        chk({tag, "_released"}, {RSP0_VALID, RSP1_VALID, BUSY}, 3'b000);
        chk({tag, "_cnt"}, OP_CNT, cnt_before + 1'b1);
    endtask

    logic grants [0:3];
    int   ngrant;

    initial begin
        RST = 1'b1;
        REQ0_VALID = 1'b0; REQ0_SEL = 1'b0; REQ0_A = '0; REQ0_B = '0;
        REQ1_VALID = 1'b0; REQ1_SEL = 1'b0; REQ1_A = '0; REQ1_B = '0;
        RSP0_READY = 1'b0; RSP1_READY = 1'b0;
        tick();
        tick();
        RST = 1'b0;
        settle();
        chk("reset_rspv", {RSP0_VALID, RSP1_VALID}, 2'b00);
        chk("reset_y", RSP_Y, 6'd0);
        chk("reset_of", RSP_OF, 1'b0);
        chk("reset_busy", BUSY, 1'b0);
        chk("reset_cnt", OP_CNT, 8'd0);
        chk("reset_ready", {REQ0_READY, REQ1_READY}, 2'b00);

        // 5 + 3 = 8
        run_single("add0", 1'b0, 1'b0, 6'd5, 6'd3, 6'd8, 1'b0, 6'd8, 1'b0, 8'd0);
        // -5 - 7 = -12
        run_single("sub1", 1'b1, 1'b1, 6'b111011, 6'd7, 6'b110100, 1'b0, 6'b110100, 1'b0, 8'd1);
        // 20 + 15 overflows: wrap -29, saturate +31
        run_single("ovf_add", 1'b0, 1'b0, 6'd20, 6'd15, 6'b100011, 1'b1, 6'b011111, 1'b1, 8'd2);
        // -32 - 1 overflows: wrap +31, saturate -32
        run_single("ovf_sub", 1'b1, 1'b1, 6'b100000, 6'd1, 6'b011111, 1'b1, 6'b100000, 1'b1, 8'd3);

        // Fairness: both requesters continuously valid after reset.
        RST = 1'b1;
        tick();
        RST = 1'b0;
        REQ0_VALID = 1'b1; REQ0_SEL = 1'b0; REQ0_A = 6'd1;  REQ0_B = 6'd1;   // -> 2
        REQ1_VALID = 1'b1; REQ1_SEL = 1'b1; REQ1_A = 6'd10; REQ1_B = 6'd4;   // -> 6
        RSP0_READY = 1'b1; RSP1_READY = 1'b1;
        ngrant = 0;
        for (int c = 0; c < 12; c++) begin
            settle();
            if (REQ0_READY || REQ1_READY) begin
                if (ngrant < 4) grants[ngrant] = REQ1_READY;
                ngrant++;
            end
            chk("rr_exclusive", RSP0_VALID & RSP1_VALID, 1'b0);
            if (RSP0_VALID) chk("rr_y0", RSP_Y, 6'd2);
            if (RSP1_VALID) chk("rr_y1", RSP_Y, 6'd6);
            tick();
        end
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;
        settle();
        chk("rr_ngrant", ngrant, 4);
        chk("rr_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b0101);
        chk("rr_cnt", OP_CNT, 8'd4);

        // Backpressure on requester 0 while requester 1 waits; RSP1_READY must be ignored.
        RSP0_READY = 1'b0;
        RSP1_READY = 1'b1;
        REQ0_VALID = 1'b1; REQ0_SEL = 1'b0; REQ0_A = 6'd2; REQ0_B = 6'd3;
        settle();
        chk("bp_ready0", REQ0_READY, 1'b1);
        tick();
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b1; REQ1_SEL = 1'b0; REQ1_A = 6'd1; REQ1_B = 6'd1;
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk("bp_rsp0v", {RSP0_VALID, RSP1_VALID}, 2'b10);
            chk("bp_y_hold", RSP_Y, 6'd5);
            chk("bp_ready1", REQ1_READY, 1'b0);
            tick();
        end
        RSP0_READY = 1'b1;
        settle();
        chk("bp_hold_last", RSP0_VALID, 1'b1);
        tick();
        RSP0_READY = 1'b0;
        settle();
        chk("bp_grant1", REQ1_READY, 1'b1);
        chk("bp_cnt", OP_CNT, 8'd5);
        tick();
        REQ1_VALID = 1'b0;
        tick();
        settle();
        chk("bp_rsp1v", {RSP0_VALID, RSP1_VALID}, 2'b01);
        chk("bp_y1", RSP_Y, 6'd2);
        tick();
        RSP1_READY = 1'b0;
        settle();
        chk("bp_cnt2", OP_CNT, 8'd6);

        // Reset during EXEC (requester 1 in flight).
        REQ1_VALID = 1'b1; REQ1_SEL = 1'b0; REQ1_A = 6'd4; REQ1_B = 6'd4;
        tick();
        REQ1_VALID = 1'b0;
        settle();
        chk("rexec_busy_pre", BUSY, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        settle();
        chk("rexec_out", {RSP0_VALID, RSP1_VALID, RSP_OF, BUSY}, 4'b0000);
        chk("rexec_y", RSP_Y, 6'd0);
        chk("rexec_cnt", OP_CNT, 8'd0);
        tick();
        settle();
        chk("rexec_stay_idle", {BUSY, RSP1_VALID}, 2'b00);

        // Reset during RESP (requester 0 granted last, so PRIO would be 1 without reset).
        REQ0_VALID = 1'b1; REQ0_SEL = 1'b0; REQ0_A = 6'd7; REQ0_B = 6'd7;
        tick();
        REQ0_VALID = 1'b0;
        tick();
        settle();
        chk("rresp_pre", {RSP0_VALID, RSP_Y}, {1'b1, 6'd14});
        RST = 1'b1;
        tick();
        RST = 1'b0;
        settle();
        chk("rresp_out", {RSP0_VALID, RSP1_VALID, RSP_OF, BUSY}, 4'b0000);
        chk("rresp_y", RSP_Y, 6'd0);
        chk("rresp_cnt", OP_CNT, 8'd0);
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        settle();
        chk("rresp_prio0", {REQ0_READY, REQ1_READY}, 2'b10);
        REQ0_VALID = 1'b0;
        REQ1_VALID = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
